// File: rtl/arb_pkg.sv
// Shared constants and types for the three-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned NREQ  = 3;  // requesters a, b, c
    localparam int unsigned IDX_W = 2;  // width of a requester index

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set request bit at ptr, ptr+1, ptr+2 (mod NREQ).
module rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] cand;
    logic           found;

    // Scan the candidates in rotated order and keep the first requester seen.
    always_comb begin
        valid = |req;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(NREQ)) begin
                cand = cand - (IDX_W + 1)'(NREQ);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/abc_arbiter.sv
// Two-state round-robin arbiter for requesters a, b, c with registered one-hot grant.
// Optional feature: define ARB_TIMEOUT_EN to force release after TIMEOUT grant cycles.
module abc_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             busy,
    output logic             timeout_err
);

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_done;
    logic             owner_req;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // gnt is one-hot, so masking isolates the owner's bits and ignores everyone else.
    assign owner_done = |(done & gnt);
    assign owner_req  = |(req & gnt);
    assign busy       = |gnt;

`ifdef ARB_TIMEOUT_EN
    logic [3:0] cnt;
    logic       terr;

    assign timeout_err = terr;

    // Arbitration FSM with grant-length counter; release beats timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            cnt    <= '0;
            terr   <= 1'b0;
        end else begin
            terr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state  <= GRANT;
                        gnt    <= NREQ'(1) << pick_idx;
                        gnt_id <= pick_idx;
                        ptr    <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                        cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (owner_done || !owner_req) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                    end else if (cnt == 4'(TIMEOUT - 1)) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                        terr   <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;

    // Arbitration FSM; a grant lasts until the owner releases it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state  <= GRANT;
                        gnt    <= NREQ'(1) << pick_idx;
                        gnt_id <= pick_idx;
                        ptr    <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
                GRANT: begin
                    if (owner_done || !owner_req) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule
